// File: rtl/inv_key_schedule.sv
// AES-128 key schedule that runs forward to the round-10 key, then walks
// backward one round key per consumer request. This lets a decryptor take the
// round keys in the order it needs them (10 down to 0).
// Each key step takes two cycles because SubWord is built from registered S-boxes.

// Single-byte AES S-box. It is a ROM with a registered read.
module sub_bytes_sbox (
  input  logic       clk,
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  // Entry for byte x sits at bits [8*(255-x) +: 8], so entry 0x00 is at the MSB end.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_base;
  assign w_base = {~i_byte, 3'b000};

  // Registered ROM read. One cycle of latency from i_byte to o_byte.
  always_ff @(posedge clk) begin
    o_byte <= SBOX[w_base +: 8];
  end
endmodule

module inv_key_schedule (
  input  logic         clk,
  input  logic         Reset,
  input  logic         start,
  input  logic [127:0] Cipherkey,
  input  logic         next,
  output logic [127:0] RoundKey,
  output logic [3:0]   round,
  output logic         valid,
  output logic         busy
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FWD_SB  = 3'd1;
  localparam logic [2:0] S_FWD_UPD = 3'd2;
  localparam logic [2:0] S_SERVE   = 3'd3;
  localparam logic [2:0] S_BWD_SB  = 3'd4;
  localparam logic [2:0] S_BWD_UPD = 3'd5;

  logic [2:0]   r_state;
  logic [127:0] r_key;
  logic [3:0]   r_step;
  logic [3:0]   r_round;
  logic         r_valid;

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_p1, w_p2, w_p3;
  logic [31:0] w_f0, w_f1, w_f2, w_f3;
  logic [31:0] w_b0;
  logic [31:0] w_sb_in, w_sb_out;
  logic [7:0]  w_rcon_fwd, w_rcon_bwd;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  assign {w_w0, w_w1, w_w2, w_w3} = r_key;

  // Undo the chained XORs of the forward step. These words only depend on the
  // key register, so they do not change between BWD_SB and BWD_UPD.
  assign w_p3 = w_w3 ^ w_w2;
  assign w_p2 = w_w2 ^ w_w1;
  assign w_p1 = w_w1 ^ w_w0;

  // The S-boxes see RotWord(p3) while going backward and RotWord(w3) otherwise.
  assign w_sb_in = (r_state == S_BWD_SB) ? {w_p3[23:0], w_p3[31:24]}
                                         : {w_w3[23:0], w_w3[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_subword
      sub_bytes_sbox u_sbox (
        .clk    (clk),
        .i_byte (w_sb_in[8*gi +: 8]),
        .o_byte (w_sb_out[8*gi +: 8])
      );
    end
  endgenerate

  assign w_rcon_fwd = rcon(r_step);
  assign w_rcon_bwd = rcon(r_round - 4'd1);

  assign w_f0 = w_w0 ^ w_sb_out ^ {w_rcon_fwd, 24'h0};
  assign w_f1 = w_w1 ^ w_f0;
  assign w_f2 = w_w2 ^ w_f1;
  assign w_f3 = w_w3 ^ w_f2;

  assign w_b0 = w_w0 ^ w_sb_out ^ {w_rcon_bwd, 24'h0};

  // Control FSM and key register. Reset overrides everything; start restarts
  // from IDLE or SERVE; next is acted on only in SERVE.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_key   <= '0;
      r_step  <= '0;
      r_round <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_key   <= Cipherkey;
            r_step  <= '0;
            r_round <= '0;
            r_valid <= 1'b0;
            r_state <= S_FWD_SB;
          end
        end
        S_FWD_SB: r_state <= S_FWD_UPD;
        S_FWD_UPD: begin
          r_key <= {w_f0, w_f1, w_f2, w_f3};
          if (r_step == 4'd9) begin
            r_round <= 4'd10;
            r_valid <= 1'b1;
            r_state <= S_SERVE;
          end else begin
            r_step  <= r_step + 4'd1;
            r_round <= r_step + 4'd1;
            r_state <= S_FWD_SB;
          end
        end
        S_SERVE: begin
          if (start) begin
            r_key   <= Cipherkey;
            r_step  <= '0;
            r_round <= '0;
            r_valid <= 1'b0;
            r_state <= S_FWD_SB;
          end else if (next) begin
            r_valid <= 1'b0;
            r_state <= (r_round != 4'd0) ? S_BWD_SB : S_IDLE;
          end
        end
        S_BWD_SB: r_state <= S_BWD_UPD;
        S_BWD_UPD: begin
          r_key   <= {w_b0, w_p1, w_p2, w_p3};
          r_round <= r_round - 4'd1;
          r_valid <= 1'b1;
          r_state <= S_SERVE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign RoundKey = r_key;
  assign round    = r_round;
  assign valid    = r_valid;
  assign busy     = (r_state != S_IDLE);
endmodule
